// File: rtl/sc_counter_pkg.sv
// Shared encodings for the sc_counter family: FSM state codes and default bus width.
package sc_counter_pkg;

  localparam int SC_COUNTER_DATAWIDTH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    EMPTY = 2'b10
  } scState_t;

endpackage

// File: rtl/sc_edge_fall_detect.sv
// One-bit falling-edge detector: pulses for one cycle when an active-low input is first seen low.
// History resets to 1 so an input already low when reset releases is not taken as an edge.
module sc_edge_fall_detect (
  input  logic SC_EDGE_CLOCK_50,
  input  logic SC_EDGE_RESET_InHigh,
  input  logic SC_EDGE_signal_InLow,
  output logic SC_EDGE_fall_OutHigh
);

  logic prevReg;

  always_ff @(posedge SC_EDGE_CLOCK_50) begin
    if (SC_EDGE_RESET_InHigh) begin
      prevReg <= 1'b1;
    end else begin
      prevReg <= SC_EDGE_signal_InLow;
    end
  end

  assign SC_EDGE_fall_OutHigh = prevReg & ~SC_EDGE_signal_InLow;

endmodule

// File: rtl/sc_counter_down.sv
// Loadable down-counter of remaining targets: preset by an active-low load, decremented once per hit edge.
// Optional macro SC_DOWNCOUNTER_AUTORELOAD_EN re-presets the last nonzero load one cycle after emptying.
module sc_counter_down
  import sc_counter_pkg::*;
#(
  parameter int COUNTER_DATAWIDTH_BUS = SC_COUNTER_DATAWIDTH
) (
  input  logic                             SC_DOWNCOUNTER_CLOCK_50,
  input  logic                             SC_DOWNCOUNTER_RESET_InHigh,
  input  logic                             SC_DOWNCOUNTER_load_InLow,
  input  logic [COUNTER_DATAWIDTH_BUS-1:0] SC_DOWNCOUNTER_data_InBus,
  input  logic                             SC_DOWNCOUNTER_dec_InLow,
  output logic [COUNTER_DATAWIDTH_BUS-1:0] SC_DOWNCOUNTER_regcount_OutBus,
  output logic                             SC_DOWNCOUNTER_eoc_OutLow,
  output logic                             SC_DOWNCOUNTER_done_OutHigh,
  output logic                             SC_DOWNCOUNTER_busy_OutHigh
);

  localparam logic [COUNTER_DATAWIDTH_BUS-1:0] COUNT_ONE = {{(COUNTER_DATAWIDTH_BUS-1){1'b0}}, 1'b1};

  scState_t                         stateReg;
  logic [COUNTER_DATAWIDTH_BUS-1:0] countReg;
  logic                             doneReg;
  logic                             decFall;
`ifdef SC_DOWNCOUNTER_AUTORELOAD_EN
  logic [COUNTER_DATAWIDTH_BUS-1:0] reloadReg;
`endif

  sc_edge_fall_detect decEdge (
    .SC_EDGE_CLOCK_50    (SC_DOWNCOUNTER_CLOCK_50),
    .SC_EDGE_RESET_InHigh(SC_DOWNCOUNTER_RESET_InHigh),
    .SC_EDGE_signal_InLow(SC_DOWNCOUNTER_dec_InLow),
    .SC_EDGE_fall_OutHigh(decFall)
  );

  // Load outranks a hit edge in the same cycle; the edge is dropped, not queued.
  always_ff @(posedge SC_DOWNCOUNTER_CLOCK_50) begin
    if (SC_DOWNCOUNTER_RESET_InHigh) begin
      stateReg  <= IDLE;
      countReg  <= '0;
      doneReg   <= 1'b0;
`ifdef SC_DOWNCOUNTER_AUTORELOAD_EN
      reloadReg <= '0;
`endif
    end else begin
      doneReg <= 1'b0;
      if (!SC_DOWNCOUNTER_load_InLow) begin
        if (SC_DOWNCOUNTER_data_InBus != '0) begin
          stateReg  <= COUNT;
          countReg  <= SC_DOWNCOUNTER_data_InBus;
`ifdef SC_DOWNCOUNTER_AUTORELOAD_EN
          reloadReg <= SC_DOWNCOUNTER_data_InBus;
`endif
        end else begin
          stateReg <= IDLE;
          countReg <= '0;
        end
      end else begin
        case (stateReg)
          COUNT: begin
            if (decFall) begin
              // Last hit lands on zero and stops there; no wrap to all-ones.
              if (countReg > COUNT_ONE) begin
                countReg <= countReg - COUNT_ONE;
              end else begin
                countReg <= '0;
                stateReg <= EMPTY;
                doneReg  <= 1'b1;
              end
            end
          end
`ifdef SC_DOWNCOUNTER_AUTORELOAD_EN
          EMPTY: begin
            if (doneReg) begin
              countReg <= reloadReg;
              stateReg <= COUNT;
            end
          end
`endif
          default: begin
          end
        endcase
      end
    end
  end

  assign SC_DOWNCOUNTER_regcount_OutBus = countReg;
  assign SC_DOWNCOUNTER_eoc_OutLow      = (stateReg != EMPTY);
  assign SC_DOWNCOUNTER_busy_OutHigh    = (stateReg == COUNT);
  assign SC_DOWNCOUNTER_done_OutHigh    = doneReg;

endmodule

// File: doc/sc_counter_down.md
Name: sc_counter_down

Overview:
Loadable down-counter for remaining-target tracking, such as aliens left in a wave.
- Presets to N, then decrements once per falling edge of an active-low hit request.
- Flags end-of-count active-low when it reaches zero.
- Pairs with the up-counting index counters: it consumes hit strobes rather than producing an index sweep.

Parameters:
- COUNTER_DATAWIDTH_BUS, 5, width of the count register and load bus.

Ports:
- SC_DOWNCOUNTER_CLOCK_50  in  1  system clock; all logic on its rising edge.
- SC_DOWNCOUNTER_RESET_InHigh  in  1  synchronous active-high reset.
- SC_DOWNCOUNTER_load_InLow  in  1  active-low preset request, level-sampled.
- SC_DOWNCOUNTER_data_InBus  in  COUNTER_DATAWIDTH_BUS  preset value.
- SC_DOWNCOUNTER_dec_InLow  in  1  active-low hit request; falling-edge detected.
- SC_DOWNCOUNTER_regcount_OutBus  out  COUNTER_DATAWIDTH_BUS  current count (register output).
- SC_DOWNCOUNTER_eoc_OutLow  out  1  low while in EMPTY.
- SC_DOWNCOUNTER_done_OutHigh  out  1  one-cycle pulse on entry to EMPTY.
- SC_DOWNCOUNTER_busy_OutHigh  out  1  high while in COUNT.

Interface decision: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (sampled at a clock edge while RESET_InHigh=1):
  - state=IDLE, count=0.
  - eoc=1, done=0, busy=0.
  - dec edge-detector history=1, so a low dec input at reset exit does not count.
- Edge detect:
  - dec_fall = prev_dec & ~dec_InLow; prev_dec <= dec_InLow every cycle.
  - A hit held low for many cycles gives exactly one decrement.
- FSM states and transitions:
  - IDLE: load with data!=0 -> COUNT, count<=data. Load with data==0 -> stays IDLE, count=0, no pulse. dec ignored.
  - COUNT: load with data!=0 -> count<=data (re-preset, stay COUNT). Load with data==0 -> IDLE, count=0. dec_fall with count>1 -> count-1. dec_fall with count==1 -> count<=0, EMPTY, done pulses next cycle.
  - EMPTY: dec ignored; count holds 0, never wraps to all-ones. Load with data!=0 -> COUNT. Load with data==0 -> IDLE.
- Priority: reset > load > dec in the same cycle. A dec_fall coinciding with load is discarded; it is not deferred.
- Latency: edge sampled at clock k -> regcount/state updated after edge k.
  - done registered: high exactly the one cycle in which state first reads EMPTY.
  - eoc and busy are decoded from registered state (glitch-free).
- Width: arithmetic modulo 2^COUNTER_DATAWIDTH_BUS, but the decrement is gated so underflow is impossible.
- Reset mid-count: returns to IDLE at that edge; no done pulse.

Optional Feature:
- Macro: SC_DOWNCOUNTER_AUTORELOAD_EN.
- Defined:
  - A reload register captures data_InBus on every accepted nonzero load; reset value 0.
  - On the cycle after entering EMPTY (the done-pulse cycle), the FSM reloads count<=reload and returns to COUNT.
  - eoc is low for exactly that one cycle.
  - An explicit load in that cycle wins.
- Undefined: no reload register; EMPTY holds until load or reset.

Decomposition:
- sc_counter_pkg:
  - state encoding constants: IDLE=2'b00, COUNT=2'b01, EMPTY=2'b10.
  - default data width constant 5.
- One natural sub-module: sc_edge_fall_detect.
  - 1-bit registered falling-edge detector.
  - Synchronous active-high reset; history resets to 1.
  - Output one-cycle pulse.
- Instantiated once for dec_InLow; reusable for fire/move buttons.

Test Plan:
- Reset then load 5'd16, 16 single-cycle dec lows spaced 3 cycles -> count 16..0, done high one cycle after 16th edge, eoc=0, busy=0.
- Load 3, hold dec low 10 cycles -> count 2 only; release/re-press -> 1.
- Load 1, dec edge and load=7 same cycle -> count 7, state COUNT, no done pulse.
- In EMPTY, apply 5 dec edges -> count stays 0, eoc stays 0, no further done pulses.
- Load 0 from IDLE and from COUNT(count=4) -> IDLE, count 0, eoc=1, busy=0.
- Reset asserted with count=9 mid-sequence -> next edge count 0, IDLE. With SC_DOWNCOUNTER_AUTORELOAD_EN, load 2 plus two dec edges -> done pulse, count reloads to 2, busy=1.
